// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock through one shared
// DIGIT-bit adder slice with a carry flop chaining digits together.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits per cycle; must divide WIDTH (NDIG = WIDTH/DIGIT cycles)
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (overrides start)
//   start     request, accepted only while busy=0
//   a, b, cin operands and carry-in, captured on accepted start
//   sub       (SERIAL_ADDER_SUB_EN only) 1 = a + ~b + cin
//   busy      high while an addition is in progress
//   done      one-cycle pulse, result valid
//   sum       registered result, held until the next completion
//   cout      carry out of bit WIDTH-1
//   overflow  carry into MSB xor carry out of MSB
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub input).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] areg, breg, rreg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, done_q;

    logic [WIDTH-1:0] bcap;
    logic [DIGIT:0]   dsum;
    logic [DIGIT-1:0] s;
    logic             cmsb;
    logic             last;
    logic [WIDTH-1:0] rnext;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is folded into the capture: a - b = a + ~b + 1.
    assign bcap = sub ? ~b : b;
`else
    assign bcap = b;
`endif

    // One digit slice: low DIGIT bits of each operand plus the chained carry.
    assign dsum = {1'b0, areg[DIGIT-1:0]}
                + {1'b0, breg[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
    assign s    = dsum[DIGIT-1:0];

    // Carry into the top bit of this digit, recovered from its sum bit.
    // For DIGIT=1 this is simply the carry flop.
    assign cmsb = s[DIGIT-1] ^ areg[DIGIT-1] ^ breg[DIGIT-1];

    // Result fills from the top, so after NDIG digits it is aligned.
    assign rnext = (rreg >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));

    assign last = (state_q == RUN) && (cnt == CW'(NDIG - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            areg   <= '0;
            breg   <= '0;
            rreg   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    areg  <= a;
                    breg  <= bcap;
                    carry <= cin;
                    cnt   <= '0;
                end
            end else begin
                areg  <= areg >> DIGIT;
                breg  <= breg >> DIGIT;
                rreg  <= rnext;
                carry <= dsum[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    sum_q  <= rnext;
                    cout_q <= dsum[DIGIT];
                    ovf_q  <= cmsb ^ dsum[DIGIT];
                    done_q <= 1'b1;
                    cnt    <= '0;
                end
            end
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table-driven bench for serial_adder.
// Runs an 8-bit/1-bit-digit instance and a 16-bit/4-bit-digit instance.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub8, sub16;
`endif

    serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(start8),
        .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .rst(rst), .start(start16),
        .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .overflow(ovf16)
    );

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    int checks   = 0;
    int failures = 0;

    logic [7:0] last_sum;
    logic       last_cout, last_ovf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one 8-bit operation and check every cycle up to the done pulse.
    task automatic run8(input vec_t v);
        logic bad;
        bad = 1'b0;
        start8 = 1'b1;
        a8 = v.a;
        b8 = v.b;
        cin8 = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = v.sub;
`endif
        tick();
        start8 = 1'b0;
        a8 = ~v.a;
        b8 = ~v.b;
        cin8 = ~v.cin;
        for (int k = 0; k < 8; k++) begin
            if (busy8 !== 1'b1 || done8 !== 1'b0 ||
                sum8 !== last_sum || cout8 !== last_cout ||
                ovf8 !== last_ovf)
                bad = 1'b1;
            tick();
        end
        chk({v.name, "_run"}, 32'(bad), 32'd0);
        chk({v.name, "_done"}, 32'(done8), 32'd1);
        chk({v.name, "_busy"}, 32'(busy8), 32'd0);
        chk({v.name, "_sum"}, 32'(sum8), 32'(v.sum));
        chk({v.name, "_cout"}, 32'(cout8), 32'(v.cout));
        chk({v.name, "_ovf"}, 32'(ovf8), 32'(v.ovf));
        last_sum  = v.sum;
        last_cout = v.cout;
        last_ovf  = v.ovf;
        tick();
        chk({v.name, "_pulse"}, 32'(done8), 32'd0);
    endtask

    initial begin
        logic saw;
        vec_t v;

        vecs.push_back('{"ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"0f_f0c", 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{"80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{"40_40", 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{"00_00c", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{"ff_ffc", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{"3c_a5", 8'h3C, 8'hA5, 1'b0, 1'b0, 8'hE1, 1'b0, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{"sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{"sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{"add_after_sub", 8'h05, 8'h07, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0});
        sub8  = 1'b0;
        sub16 = 1'b0;
`endif

        // Reset with start asserted: reset must win.
        rst = 1'b1;
        start8 = 1'b1;
        a8 = 8'h12;
        b8 = 8'h34;
        cin8 = 1'b1;
        start16 = 1'b1;
        a16 = 16'h1234;
        b16 = 16'h4321;
        cin16 = 1'b0;
        tick();
        tick();
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'(sum8), 32'd0);
        chk("rst_cout8", 32'(cout8), 32'd0);
        chk("rst_ovf8", 32'(ovf8), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        chk("rst_sum16", 32'(sum16), 32'd0);
        start8 = 1'b0;
        start16 = 1'b0;
        rst = 1'b0;
        tick();
        last_sum  = 8'h00;
        last_cout = 1'b0;
        last_ovf  = 1'b0;

        foreach (vecs[i]) run8(vecs[i]);

        // Start while busy is ignored; operands are not re-sampled.
        start8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h20;
        cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        a8 = 8'h00;
        b8 = 8'h00;
        tick();
        tick();
        start8 = 1'b1;
        a8 = 8'hAA;
        tick();
        start8 = 1'b0;
        chk("ign_busy", 32'(busy8), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("ign_done", 32'(done8), 32'd1);
        chk("ign_sum", 32'(sum8), 32'h30);
        chk("ign_cout", 32'(cout8), 32'd0);
        tick();
        chk("ign_idle", 32'(busy8), 32'd0);
        last_sum  = 8'h30;
        last_cout = 1'b0;
        last_ovf  = 1'b0;

        // Reset mid-operation aborts with no done pulse.
        start8 = 1'b1;
        a8 = 8'h55;
        b8 = 8'h55;
        cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_sum", 32'(sum8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        saw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) saw = 1'b1;
            tick();
        end
        chk("abort_quiet", 32'(saw), 32'd0);
        last_sum  = 8'h00;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        v = '{"post_abort", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
        run8(v);

        // 16-bit, 4-bit digits, start held high across the done cycle.
        start16 = 1'b1;
        a16 = 16'hFFFF;
        b16 = 16'h0001;
        cin16 = 1'b0;
        tick();
        a16 = 16'h1234;
        b16 = 16'h1111;
        tick();
        tick();
        tick();
        chk("w16_busy", 32'(busy16), 32'd1);
        chk("w16_sum_hold", 32'(sum16), 32'd0);
        tick();
        chk("w16_done1", 32'(done16), 32'd1);
        chk("w16_busy1", 32'(busy16), 32'd0);
        chk("w16_sum1", 32'(sum16), 32'h0000);
        chk("w16_cout1", 32'(cout16), 32'd1);
        chk("w16_ovf1", 32'(ovf16), 32'd0);
        tick();
        start16 = 1'b0;
        chk("w16_restart", 32'(busy16), 32'd1);
        chk("w16_hold2", 32'(sum16), 32'h0000);
        tick();
        tick();
        tick();
        chk("w16_nodone", 32'(done16), 32'd0);
        tick();
        chk("w16_done2", 32'(done16), 32'd1);
        chk("w16_sum2", 32'(sum16), 32'h2345);
        chk("w16_cout2", 32'(cout16), 32'd0);
        chk("w16_ovf2", 32'(ovf16), 32'd0);
        tick();
        chk("w16_idle", 32'(busy16), 32'd0);
        chk("w16_pulse", 32'(done16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
